// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter for a shared single-port data memory, burst-limited round robin.
// Latency: grant is combinational in the request cycle; read data/rvalid/err arrive one cycle later.
// Backpressure: a requester holds req/addr/data until gnt; the loser simply waits (no queueing).
module dmem_arbiter #(
    parameter int ADDR_BITS  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  err0,
    output logic                  err1,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_do
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic             rr_ptr;

    logic                  win_vld;
    logic                  win_sel;
    logic                  we_w;
    logic [DATA_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] wdata_w;
    logic                  in_range;
    logic                  owner_hit;
    logic [CNT_W-1:0]      cnt_inc;

    // Winner selection; nothing wins while reset is held so the access is suppressed.
    always_comb begin
        win_vld = 1'b0;
        win_sel = 1'b0;
        if (rst_n) begin
            case (state)
                OWN0: begin
                    if (req0 && ((burst_cnt < CNT_MAX) || !req1)) begin
                        win_vld = 1'b1;
                        win_sel = 1'b0;
                    end else if (req1) begin
                        win_vld = 1'b1;
                        win_sel = 1'b1;
                    end
                end
                OWN1: begin
                    if (req1 && ((burst_cnt < CNT_MAX) || !req0)) begin
                        win_vld = 1'b1;
                        win_sel = 1'b1;
                    end else if (req0) begin
                        win_vld = 1'b1;
                        win_sel = 1'b0;
                    end
                end
                default: begin
                    if (req0 && req1) begin
                        win_vld = 1'b1;
                        win_sel = rr_ptr;
                    end else if (req0) begin
                        win_vld = 1'b1;
                        win_sel = 1'b0;
                    end else if (req1) begin
                        win_vld = 1'b1;
                        win_sel = 1'b1;
                    end
                end
            endcase
        end
    end

    assign we_w     = win_sel ? we1    : we0;
    assign addr_w   = win_sel ? addr1  : addr0;
    assign wdata_w  = win_sel ? wdata1 : wdata0;
    assign in_range = (addr_w[DATA_WIDTH-1:ADDR_BITS] == '0);

    assign gnt0 = win_vld & ~win_sel;
    assign gnt1 = win_vld &  win_sel;

    always_comb begin
        mem_we   = win_vld & we_w & in_range;
        mem_addr = '0;
        mem_di   = '0;
        if (win_vld) begin
            mem_addr[ADDR_BITS-1:0] = addr_w[ADDR_BITS-1:0];
            mem_di                  = wdata_w;
        end
    end

    assign owner_hit = ((state == OWN0) && !win_sel) || ((state == OWN1) && win_sel);
    assign cnt_inc   = (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_ptr    <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            if (win_vld) begin
                state     <= win_sel ? OWN1 : OWN0;
                burst_cnt <= owner_hit ? cnt_inc : CNT_ONE;
                rr_ptr    <= ~win_sel;
                // Out-of-range accesses report an error and leave rdata untouched.
                if (!in_range) begin
                    if (win_sel) err1 <= 1'b1;
                    else         err0 <= 1'b1;
                end else if (!we_w) begin
                    if (win_sel) begin
                        rdata1  <= mem_do;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= mem_do;
                        rvalid0 <= 1'b1;
                    end
                end
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

endmodule
